fifo_access_arbiter: RTL and testbench

Controller that shares one 8-deep, 32-bit synchronous FIFO between four write requesters and one read consumer. It sequences the FIFO's single-operation-per-cycle command port (enable, read, write, synchronous pointer reset) and keeps its own authoritative occupancy count. It also sends the FIFO its initial pointer-clear after reset. It sits directly in front of the FIFO; requesters and the consumer never drive the FIFO themselves.

---
 rtl/fifo_access_arbiter_if.sv | 39 +++
 rtl/fifo_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fifo_access_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_access_arbiter_if.sv
// Requester, consumer and FIFO command bundle for fifo_access_arbiter.
// The master side drives requests; the slave side is the arbiter.
interface fifo_access_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic               rd_req;
    logic               rd_ack;
    logic               rd_valid;
    logic               flush;
    logic               fifo_en;
    logic               fifo_rd;
    logic               fifo_wr;
    logic               fifo_rst;
    logic [DW-1:0]      fifo_din;
    logic [LW-1:0]      level;
    logic               full;
    logic               empty;

    modport master (
        output req, wdata, rd_req, flush,
        input  gnt, rd_ack, rd_valid,
        input  fifo_en, fifo_rd, fifo_wr, fifo_rst, fifo_din,
        input  level, full, empty
    );

    modport slave (
        input  req, wdata, rd_req, flush,
        output gnt, rd_ack, rd_valid,
        output fifo_en, fifo_rd, fifo_wr, fifo_rst, fifo_din,
        output level, full, empty
    );
endinterface

// File: rtl/fifo_access_arbiter.sv
// Shares one synchronous FIFO between NREQ round-robin writers and a
// single reader, with anti-starvation for writers and its own level count.
module fifo_access_arbiter #(
    parameter int NREQ         = 4,
    parameter int DW           = 32,
    parameter int DEPTH        = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_access_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            ack_q, ack_d;
    logic            rdv_q, rdv_d;
    logic            en_q, en_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            rst_q, rst_d;
    logic [DW-1:0]   din_q, din_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   sel;
    logic            found;
    logic            is_full;
    logic            is_empty;
    logic            do_wr;
    logic            do_rd;

    // Held requests are masked while their grant is on the bus.
    assign elig     = bus.req & ~gnt_q;
    assign is_full  = (level_q == LW'(DEPTH));
    assign is_empty = (level_q == '0);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IW'((int'(rr_q) + off) % NREQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        gnt_d    = '0;
        ack_d    = 1'b0;
        rdv_d    = ack_q;
        en_d     = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        rst_d    = 1'b0;
        din_d    = din_q;
        do_wr    = 1'b0;
        do_rd    = 1'b0;

        case (state_q)
            INIT: begin
                en_d    = 1'b1;
                rst_d   = 1'b1;
                level_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (bus.flush) begin
                    en_d     = 1'b1;
                    rst_d    = 1'b1;
                    level_d  = '0;
                    starve_d = '0;
                end else if (found && !is_full &&
                             starve_q == SW'(STARVE_LIMIT)) begin
                    do_wr = 1'b1;
                end else if (bus.rd_req && !is_empty) begin
                    do_rd = 1'b1;
                    if (found && !is_full &&
                        starve_q != SW'(STARVE_LIMIT))
                        starve_d = starve_q + SW'(1);
                end else if (found && !is_full) begin
                    do_wr = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        if (do_wr) begin
            en_d     = 1'b1;
            wr_d     = 1'b1;
            din_d    = bus.wdata[sel*DW +: DW];
            gnt_d    = NREQ'(1) << sel;
            rr_d     = sel;
            starve_d = '0;
            level_d  = level_q + LW'(1);
        end
        if (do_rd) begin
            en_d    = 1'b1;
            rd_d    = 1'b1;
            ack_d   = 1'b1;
            level_d = level_q - LW'(1);
        end

        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= INIT;
            level_q  <= '0;
            rr_q     <= IW'(NREQ - 1);
            starve_q <= '0;
            gnt_q    <= '0;
            ack_q    <= 1'b0;
            rdv_q    <= 1'b0;
            en_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rst_q    <= 1'b0;
            din_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rdv_q    <= rdv_d;
            en_q     <= en_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rst_q    <= rst_d;
            din_q    <= din_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rd_ack   = ack_q;
    assign bus.rd_valid = rdv_q;
    assign bus.fifo_en  = en_q;
    assign bus.fifo_rd  = rd_q;
    assign bus.fifo_wr  = wr_q;
    assign bus.fifo_rst = rst_q;
    assign bus.fifo_din = din_q;
    assign bus.level    = level_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed scoreboard bench for fifo_access_arbiter.
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_fifo_access_arbiter;
    localparam int K_IDLE = 0;
    localparam int K_RST  = 1;
    localparam int K_RD   = 2;
    localparam int K_WR   = 3;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        en;
        logic        rd;
        logic        wr;
        logic        rst;
        logic        ack;
        logic        rdv;
        logic [3:0]  lvl;
        logic [31:0] din;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   wseq[4] = '{0, 0, 0, 0};
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    int   prev_idx = 0;
    logic [31:0] last_din = '0;

    fifo_access_arbiter_if #(.NREQ(4), .DW(32), .DEPTH(8)) bus ();

    fifo_access_arbiter #(
        .NREQ(4), .DW(32), .DEPTH(8), .STARVE_LIMIT(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the hand-computed response.
    task automatic step(input logic [3:0] rq, input logic rdq,
                        input logic fl, input int kind, input int idx,
                        input int lvl);
        exp_t e;
        if (prev_wr) wseq[prev_idx]++;
        for (int i = 0; i < 4; i++)
            bus.wdata[i*32 +: 32] = 32'hC0DE_0000 + 32'(wseq[i] * 16 + i);
        bus.req    = rq;
        bus.rd_req = rdq;
        bus.flush  = fl;
        e     = '0;
        e.lvl = 4'(lvl);
        e.rdv = prev_rd;
        case (kind)
            K_RST: begin e.en = 1'b1; e.rst = 1'b1; end
            K_RD:  begin e.en = 1'b1; e.rd = 1'b1; e.ack = 1'b1; end
            K_WR: begin
                e.en     = 1'b1;
                e.wr     = 1'b1;
                e.gnt    = 4'(1 << idx);
                last_din = bus.wdata[idx*32 +: 32];
            end
            default: ;
        endcase
        e.din    = last_din;
        prev_rd  = (kind == K_RD);
        prev_wr  = (kind == K_WR);
        prev_idx = idx;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (!reset) begin
                check("reset_outs",
                      64'({bus.gnt, bus.rd_ack, bus.rd_valid, bus.fifo_en,
                           bus.fifo_rd, bus.fifo_wr, bus.fifo_rst,
                           bus.full, bus.empty, bus.level, bus.fifo_din}),
                      64'({4'b0, 7'b0, 1'b1, 4'd0, 32'd0}));
            end else if (q.size() > 0) begin
                e = q.pop_front();
                check("cmd",
                      64'({bus.gnt, bus.fifo_en, bus.fifo_rd, bus.fifo_wr,
                           bus.fifo_rst, bus.rd_ack}),
                      64'({e.gnt, e.en, e.rd, e.wr, e.rst, e.ack}));
                check("rd_valid", 64'(bus.rd_valid), 64'(e.rdv));
                check("level", 64'(bus.level), 64'(e.lvl));
                check("full_empty", 64'({bus.full, bus.empty}),
                      64'({e.lvl == 4'd8, e.lvl == 4'd0}));
                check("fifo_din", 64'(bus.fifo_din), 64'(e.din));
            end
        end
    end

    task automatic quiet();
        bus.req    = '0;
        bus.rd_req = 1'b0;
        bus.flush  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        bus.wdata = '0;
        quiet();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // INIT pointer clear, then idle
        step(4'b0000, 0, 0, K_RST, 0, 0);
        step(4'b0000, 0, 0, K_IDLE, 0, 0);
        step(4'b0000, 0, 0, K_IDLE, 0, 0);

        // all requesters, round-robin fill to full, then blocked
        for (int i = 0; i < 8; i++)
            step(4'b1111, 0, 0, K_WR, i % 4, i + 1);
        step(4'b1111, 0, 0, K_IDLE, 0, 8);
        step(4'b1111, 0, 0, K_IDLE, 0, 8);
        step(4'b0000, 0, 0, K_IDLE, 0, 8);

        // drain with reads until empty
        for (int i = 0; i < 8; i++)
            step(4'b0000, 1, 0, K_RD, 0, 7 - i);
        step(4'b0000, 1, 0, K_IDLE, 0, 0);

        // refill to 4, then starvation forces a write for requester 2
        for (int i = 0; i < 4; i++)
            step(4'b1111, 0, 0, K_WR, i, i + 1);
        step(4'b0100, 1, 0, K_RD, 0, 3);
        step(4'b0100, 1, 0, K_RD, 0, 2);
        step(4'b0100, 1, 0, K_RD, 0, 1);
        step(4'b0100, 1, 0, K_WR, 2, 2);
        step(4'b0000, 1, 0, K_RD, 0, 1);
        step(4'b0000, 1, 0, K_RD, 0, 0);
        step(4'b0000, 1, 0, K_IDLE, 0, 0);

        // single requester held for two cycles gets one grant
        step(4'b0010, 0, 0, K_WR, 1, 1);
        step(4'b0010, 0, 0, K_IDLE, 0, 1);
        step(4'b0000, 0, 0, K_IDLE, 0, 1);

        // fill to 5, flush beats concurrent req and rd_req
        step(4'b1111, 0, 0, K_WR, 2, 2);
        step(4'b1111, 0, 0, K_WR, 3, 3);
        step(4'b1111, 0, 0, K_WR, 0, 4);
        step(4'b1111, 0, 0, K_WR, 1, 5);
        step(4'b1111, 1, 1, K_RST, 0, 0);
        step(4'b1111, 1, 0, K_WR, 2, 1);
        step(4'b1111, 1, 0, K_RD, 0, 0);
        step(4'b0000, 0, 1, K_RST, 0, 0);
        step(4'b0000, 0, 0, K_IDLE, 0, 0);

        // mid-operation asynchronous reset, then INIT reruns
        step(4'b1111, 0, 0, K_WR, 3, 1);
        step(4'b1111, 0, 0, K_WR, 0, 2);
        quiet();
        reset    = 1'b0;
        prev_rd  = 1'b0;
        prev_wr  = 1'b0;
        last_din = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(4'b0000, 0, 0, K_RST, 0, 0);
        step(4'b1111, 0, 0, K_WR, 0, 1);
        step(4'b0000, 0, 0, K_IDLE, 0, 1);

        quiet();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
